// File: rtl/combiner_pkg.sv
// Shared operator encodings and the per-bit combine function for the combiner block.
// Used by the RTL and by the bench so both agree on the operator semantics.
package combiner_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_OR  = 2'd0;
    localparam op_t OP_AND = 2'd1;
    localparam op_t OP_XOR = 2'd2;
    localparam op_t OP_MAJ = 2'd3;

    // Applied independently at each bit position of the three lanes.
    function automatic logic combine(input op_t op, input logic a, input logic b, input logic c);
        logic r;
        case (op)
            OP_AND:  r = a & b & c;
            OP_XOR:  r = a ^ b ^ c;
            OP_MAJ:  r = (a & b) | (a & c) | (b & c);
            default: r = a | b | c;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/combiner_reg.sv
// WIDTH-bit enable-hold register with asynchronous active-low reset to RST_VAL.
module combiner_reg #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/combiner.sv
// Registered three-lane bitwise combiner with hold; out comes straight from the state register.
// Optional COMBINER_CHANGE_FLAG_EN adds a registered one-cycle 'changed' pulse output.
module combiner
    import combiner_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter int               OP      = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             enable,
    output logic [WIDTH-1:0] out
`ifdef COMBINER_CHANGE_FLAG_EN
    ,
    output logic             changed
`endif
);

    // Out-of-range operator codes fall back to OR rather than wrapping to 2 bits.
    localparam op_t OP_EFF = (OP >= 0 && OP <= 3) ? op_t'(OP) : OP_OR;

    if (OP < 0 || OP > 3) begin : g_bad_op
        $warning("combiner: OP=%0d is not a legal operator, using OR", OP);
    end

    logic [WIDTH-1:0] comb_d;
    logic [WIDTH-1:0] ff_out;

    always_comb begin
        comb_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            comb_d[i] = combine(OP_EFF, in1[i], in2[i], in3[i]);
        end
    end

    combiner_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_state (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (enable),
        .d_i   (comb_d),
        .q_o   (ff_out)
    );

    assign out = ff_out;

`ifdef COMBINER_CHANGE_FLAG_EN
    logic changed_q;
    logic changed_d;

    assign changed_d = enable && (comb_d != ff_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;
`endif

endmodule

// File: tb/tb_combiner.sv
// Directed bench for combiner: reset, exhaustive OR, hold, async reset, operators, change flag.
module tb_combiner;
    import combiner_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       a1, a2, a3;
    logic [3:0] b1, b2, b3;
    logic       out_or;
    logic [3:0] out_and, out_xor, out_maj;
`ifdef COMBINER_CHANGE_FLAG_EN
    logic       chg_or;
    logic       chg_and, chg_xor, chg_maj;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    combiner #(.WIDTH(1), .OP(0)) u_or (
        .clk(clk), .rst_n(rst_n), .in1(a1), .in2(a2), .in3(a3),
        .enable(enable), .out(out_or)
`ifdef COMBINER_CHANGE_FLAG_EN
        , .changed(chg_or)
`endif
    );

    combiner #(.WIDTH(4), .OP(1)) u_and (
        .clk(clk), .rst_n(rst_n), .in1(b1), .in2(b2), .in3(b3),
        .enable(enable), .out(out_and)
`ifdef COMBINER_CHANGE_FLAG_EN
        , .changed(chg_and)
`endif
    );

    combiner #(.WIDTH(4), .OP(2)) u_xor (
        .clk(clk), .rst_n(rst_n), .in1(b1), .in2(b2), .in3(b3),
        .enable(enable), .out(out_xor)
`ifdef COMBINER_CHANGE_FLAG_EN
        , .changed(chg_xor)
`endif
    );

    combiner #(.WIDTH(4), .OP(3)) u_maj (
        .clk(clk), .rst_n(rst_n), .in1(b1), .in2(b2), .in3(b3),
        .enable(enable), .out(out_maj)
`ifdef COMBINER_CHANGE_FLAG_EN
        , .changed(chg_maj)
`endif
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        {a1, a2, a3} = 3'b111;
        b1 = 4'hF; b2 = 4'hF; b3 = 4'hF;

        #2;
        chk("reset_async", {3'b0, out_or}, 4'b0000);
        tick();
        chk("reset_en_hi_1", {3'b0, out_or}, 4'b0000);
        chk("reset_and", out_and, 4'b0000);
        tick();
        chk("reset_en_hi_2", {3'b0, out_or}, 4'b0000);
        chk("reset_maj", out_maj, 4'b0000);
`ifdef COMBINER_CHANGE_FLAG_EN
        chk("reset_changed", {3'b0, chg_or}, 4'b0000);
`endif

        rst_n = 1'b1;
        tick();
        chk("post_reset_capture", {3'b0, out_or}, 4'b0001);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            {a1, a2, a3} = v;
            tick();
            chk($sformatf("or_%03b", v), {3'b0, out_or}, {3'b0, |v});
        end

        {a1, a2, a3} = 3'b100;
        tick();
        chk("hold_load", {3'b0, out_or}, 4'b0001);
        enable = 1'b0;
        {a1, a2, a3} = 3'b000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold_%0d", i), {3'b0, out_or}, 4'b0001);
        end
        enable = 1'b1;
        tick();
        chk("reenable", {3'b0, out_or}, 4'b0000);

        {a1, a2, a3} = 3'b111;
        tick();
        chk("pre_async", {3'b0, out_or}, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_mid_cycle", {3'b0, out_or}, 4'b0000);
        #1;
        rst_n = 1'b1;
        #1;
        chk("async_released_before_edge", {3'b0, out_or}, 4'b0000);
        tick();
        chk("recapture", {3'b0, out_or}, 4'b0001);

        b1 = 4'b1100; b2 = 4'b1010; b3 = 4'b0110;
        tick();
        chk("op_and_v1", out_and, 4'b0000);
        chk("op_xor_v1", out_xor, 4'b0000);
        chk("op_maj_v1", out_maj, 4'b1110);

        b1 = 4'b1111; b2 = 4'b0011; b3 = 4'b0101;
        tick();
        chk("op_and_v2", out_and, 4'b0001);
        chk("op_xor_v2", out_xor, 4'b1001);
        chk("op_maj_v2", out_maj, 4'b0111);

        enable = 1'b0;
        b1 = 4'b0000; b2 = 4'b1111; b3 = 4'b1000;
        tick();
        chk("hold_xor_w4", out_xor, 4'b1001);
        chk("hold_maj_w4", out_maj, 4'b0111);
        enable = 1'b1;
        tick();
        chk("op_xor_v3", out_xor, 4'b0111);
        chk("op_maj_v3", out_maj, 4'b1000);

`ifdef COMBINER_CHANGE_FLAG_EN
        {a1, a2, a3} = 3'b000;
        tick();
        {a1, a2, a3} = 3'b100;
        tick();
        chk("changed_0to1", {3'b0, chg_or}, 4'b0001);
        tick();
        chk("changed_1to1", {3'b0, chg_or}, 4'b0000);
        {a1, a2, a3} = 3'b000;
        tick();
        chk("changed_1to0", {3'b0, chg_or}, 4'b0001);
        enable = 1'b0;
        {a1, a2, a3} = 3'b111;
        tick();
        chk("changed_disabled", {3'b0, chg_or}, 4'b0000);
        chk("changed_disabled_out", {3'b0, out_or}, 4'b0000);
        tick();
        chk("changed_disabled_2", {3'b0, chg_or}, 4'b0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
